// File: rtl/async_input_pkg.sv
// Shared constants and helpers for the async input conditioner.
// Event-select encodings and the effective debounce limit rule live here.
package async_input_pkg;

  localparam logic [1:0] EVT_NONE = 2'b00;
  localparam logic [1:0] EVT_RISE = 2'b01;
  localparam logic [1:0] EVT_FALL = 2'b10;
  localparam logic [1:0] EVT_BOTH = 2'b11;

  // A zero limit would never let the level move, so it is treated as 1.
  function automatic logic [31:0] eff_limit(input logic en, input logic [31:0] limit);
    if (!en || limit == 32'd0) return 32'd1;
    return limit;
  endfunction

endpackage

// File: rtl/async_input_cond_ch.sv
// One conditioner channel: sync chain, debounce filter, registered edges, stretcher, event counter.
// Latency in -> level is SYNC_STAGES + L cycles; edge pulses follow one cycle later. No backpressure.
module input_cond_ch
  import async_input_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1,
  parameter int   DEBOUNCE_W  = 16,
  parameter int   STRETCH_W   = 24,
  parameter int   CNT_W       = 8
) (
  input  logic                  clk27,
  input  logic                  reset_n,
  input  logic                  raw,
  input  logic                  debounce_en,
  input  logic [DEBOUNCE_W-1:0] debounce_limit,
  input  logic [1:0]            evt_sel,
  input  logic                  evt_cnt_clr,
  output logic                  level,
  output logic                  rise,
  output logic                  fall,
  output logic                  stretch,
  output logic [CNT_W-1:0]      evt_cnt
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   level_d;
  logic                   evt;
  logic [DEBOUNCE_W-1:0]  dcnt;
  logic [STRETCH_W-1:0]   scnt;
  logic [31:0]            lim_m1;

  assign s       = sync[SYNC_STAGES-1];
  assign lim_m1  = eff_limit(debounce_en, 32'(debounce_limit)) - 32'd1;
  assign evt     = (evt_sel[1] & fall) | (evt_sel[0] & rise);
  assign stretch = (scnt != '0);

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= {SYNC_STAGES{RESET_VAL}};
      level   <= RESET_VAL;
      level_d <= RESET_VAL;
      dcnt    <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      scnt    <= '0;
      evt_cnt <= '0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], raw};
      level_d <= level;
      rise    <= level & ~level_d;
      fall    <= ~level & level_d;

      // >= rather than == so a limit lowered mid-count still releases the level.
      if (s == level) begin
        dcnt <= '0;
      end else if (32'(dcnt) >= lim_m1) begin
        level <= s;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end

      if (evt)              scnt <= '1;
      else if (scnt != '0)  scnt <= scnt - 1'b1;

      if (evt_cnt_clr)      evt_cnt <= evt ? CNT_W'(1) : '0;
      else if (evt)         evt_cnt <= evt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/async_input_conditioner.sv
// Multi-channel conditioner for asynchronous board inputs; NUM_CH independent channel instances.
// Latency in_i -> level_o is SYNC_STAGES + L cycles; edge pulses one cycle later. No backpressure.
module async_input_conditioner
  import async_input_pkg::*;
#(
  parameter int                NUM_CH      = 4,
  parameter int                SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] RESET_VAL   = {NUM_CH{1'b1}},
  parameter int                DEBOUNCE_W  = 16,
  parameter int                STRETCH_W   = 24,
  parameter int                CNT_W       = 8
) (
  input  logic                    clk27,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       in_i,
  input  logic [NUM_CH-1:0]       debounce_en,
  input  logic [DEBOUNCE_W-1:0]   debounce_limit,
  input  logic [2*NUM_CH-1:0]     evt_sel,
  input  logic [NUM_CH-1:0]       evt_cnt_clr,
  output logic [NUM_CH-1:0]       level_o,
  output logic [NUM_CH-1:0]       rise_o,
  output logic [NUM_CH-1:0]       fall_o,
  output logic [NUM_CH-1:0]       stretch_o,
  output logic [NUM_CH*CNT_W-1:0] evt_cnt_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    input_cond_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (RESET_VAL[i]),
      .DEBOUNCE_W  (DEBOUNCE_W),
      .STRETCH_W   (STRETCH_W),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk27          (clk27),
      .reset_n        (reset_n),
      .raw            (in_i[i]),
      .debounce_en    (debounce_en[i]),
      .debounce_limit (debounce_limit),
      .evt_sel        (evt_sel[2*i +: 2]),
      .evt_cnt_clr    (evt_cnt_clr[i]),
      .level          (level_o[i]),
      .rise           (rise_o[i]),
      .fall           (fall_o[i]),
      .stretch        (stretch_o[i]),
      .evt_cnt        (evt_cnt_o[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_async_input_conditioner.sv
// Scoreboard bench: expected edge pulses are queued at drive time and matched as the DUT emits them.
module tb_async_input_conditioner;

  logic        clk27 = 1'b0;
  logic        reset_n;
  logic [1:0]  in_i, debounce_en, evt_cnt_clr;
  logic [15:0] debounce_limit;
  logic [3:0]  evt_sel;
  logic [1:0]  level_o, rise_o, fall_o, stretch_o;
  logic [7:0]  evt_cnt_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_q[$];

  async_input_conditioner #(
    .NUM_CH(2), .SYNC_STAGES(2), .RESET_VAL(2'b11),
    .DEBOUNCE_W(16), .STRETCH_W(4), .CNT_W(4)
  ) dut (
    .clk27(clk27), .reset_n(reset_n), .in_i(in_i), .debounce_en(debounce_en),
    .debounce_limit(debounce_limit), .evt_sel(evt_sel), .evt_cnt_clr(evt_cnt_clr),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .stretch_o(stretch_o),
    .evt_cnt_o(evt_cnt_o)
  );

  always #5 clk27 = ~clk27;
  always @(posedge clk27) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int code(input int c, input int ch, input int r);
    return c * 4 + ch * 2 + r;
  endfunction

  task automatic push(input int lat, input int ch, input int r);
    exp_q.push_back(code(cyc + lat, ch, r));
  endtask

  task automatic tick();
    @(negedge clk27);
  endtask

  // Every observed pulse must match the oldest outstanding expectation (cycle, channel, direction).
  always @(negedge clk27) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (rise_o[ch] || fall_o[ch]) begin
        if (exp_q.size() == 0) chk("pulse_unexp", code(cyc, ch, int'(rise_o[ch])), 32'hffff_ffff);
        else                   chk("pulse", code(cyc, ch, int'(rise_o[ch])), exp_q.pop_front());
      end
    end
  end

  initial begin
    int c, len, first, last;
    reset_n = 1'b0; in_i = 2'b11; debounce_en = 2'b00; debounce_limit = 16'd0;
    evt_sel = 4'b1111; evt_cnt_clr = 2'b00;

    // Reset release: level holds reset value, no spurious edges
    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    chk("rst_level", level_o, 2'b11);
    chk("rst_cnt", evt_cnt_o, 8'h00);
    chk("rst_stretch", stretch_o, 2'b00);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("quiet", rise_o | fall_o, 2'b00);
      chk("quiet_level", level_o, 2'b11);
    end
    chk("rst_cnt_after", evt_cnt_o, 8'h00);

    // Undebounced fall: level at +3, fall pulse at +4
    c = cyc;
    in_i[0] = 1'b0; push(4, 0, 0);
    repeat (2) tick();
    chk("nodb_level_c2", level_o[0], 1'b1);
    tick();
    chk("nodb_level_c3", level_o[0], 1'b0);
    repeat (5) tick();
    in_i[0] = 1'b1; push(4, 0, 1);
    repeat (25) tick();

    // Debounce L=4 on ch1: glitch rejected, 4-cycle pulse accepted
    debounce_en = 2'b10; debounce_limit = 16'd4;
    tick();
    in_i[1] = 1'b0;
    repeat (3) tick();
    in_i[1] = 1'b1;
    repeat (3) tick();
    chk("glitch_mid", level_o[1], 1'b1);
    repeat (9) tick();
    chk("glitch_end", level_o[1], 1'b1);
    in_i[1] = 1'b0; push(7, 1, 0);
    repeat (4) tick();
    in_i[1] = 1'b1; push(7, 1, 1);
    tick();
    chk("db_level_c5", level_o[1], 1'b1);
    tick();
    chk("db_level_c6", level_o[1], 1'b0);
    repeat (10) tick();
    chk("db_level_back", level_o[1], 1'b1);

    // Stretcher: single event, then retrigger at stretch cycle 10
    evt_cnt_clr = 2'b01;
    tick();
    evt_cnt_clr = 2'b00;
    chk("clr_cnt0", evt_cnt_o[3:0], 4'd0);
    c = cyc; len = 0; first = -1; last = -1;
    in_i[0] = 1'b0; push(4, 0, 0);
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (stretch_o[0]) begin
        len++;
        if (first < 0) first = cyc - c;
      end
    end
    chk("stretch_len1", len, 15);
    chk("stretch_first1", first, 5);
    c = cyc; len = 0;
    in_i[0] = 1'b1; push(4, 0, 1);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (stretch_o[0]) begin
        len++;
        last = cyc - c;
      end
      if (i == 10) begin
        in_i[0] = 1'b0; push(4, 0, 0);
      end
    end
    chk("stretch_len2", len, 25);
    chk("stretch_last2", last, 29);
    chk("cnt0_both", evt_cnt_o[3:0], 4'd3);
    chk("cnt1_both", evt_cnt_o[7:4], 4'd2);

    // Rise-only counting with wrap at 16
    evt_sel[1:0] = 2'b01; evt_cnt_clr = 2'b01;
    tick();
    evt_cnt_clr = 2'b00;
    for (int n = 0; n < 17; n++) begin
      in_i[0] = 1'b1; push(4, 0, 1);
      repeat (4) tick();
      in_i[0] = 1'b0; push(4, 0, 0);
      repeat (4) tick();
    end
    repeat (8) tick();
    chk("cnt0_wrap", evt_cnt_o[3:0], 4'd1);
    chk("cnt1_hold", evt_cnt_o[7:4], 4'd2);

    // Clear coincident with a counted edge
    in_i[0] = 1'b1; push(4, 0, 1);
    repeat (4) tick();
    evt_cnt_clr = 2'b01;
    tick();
    evt_cnt_clr = 2'b00;
    chk("clr_and_evt", evt_cnt_o[3:0], 4'd1);

    // Reset mid-stretch (ch0) and mid-debounce (ch1)
    in_i[1] = 1'b0;
    repeat (3) tick();
    chk("stretch_pre_rst", stretch_o[0], 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_stretch", stretch_o, 2'b00);
    chk("mid_rst_cnt", evt_cnt_o, 8'h00);
    chk("mid_rst_level", level_o, 2'b11);
    chk("mid_rst_edges", rise_o | fall_o, 2'b00);
    in_i = 2'b11;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_quiet", rise_o | fall_o, 2'b00);
    end
    chk("post_rst_level", level_o, 2'b11);
    chk("post_rst_cnt", evt_cnt_o, 8'h00);
    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/async_input_conditioner.md
Name: async_input_conditioner

Overview:
Parametrised, multi-channel conditioner for asynchronous board inputs such as keys, IR receiver lines and cross-domain strobes, in the clk27 CPU domain. Per channel it provides:
- a synchronizer chain and optional debounce filter;
- rise/fall pulse detection;
- a retriggerable pulse stretcher for LED indication;
- a wrapping event counter for the sys_status PIO.

It replaces the ad-hoc btn/ir_rx/resync sync registers and resync LED counter in the board top-levels.

Parameters:
NUM_CH, 4, number of independent input channels
SYNC_STAGES, 2, synchronizer flops per channel (min 2)
RESET_VAL, {NUM_CH{1'b1}}, per-channel reset level of sync chain and filtered level
DEBOUNCE_W, 16, width of debounce counter and limit
STRETCH_W, 24, width of stretch counter; stretch length is 2^STRETCH_W-1 cycles
CNT_W, 8, width of each event counter

Ports:
clk27  in  1  system clock
reset_n  in  1  reset
in_i  in  NUM_CH  raw asynchronous inputs
debounce_en  in  NUM_CH  per-channel debounce enable (quasi-static)
debounce_limit  in  DEBOUNCE_W  stable cycles required before the level changes; shared by all channels
evt_sel  in  2*NUM_CH  per-channel event select: 00 none, 01 rise, 10 fall, 11 both
evt_cnt_clr  in  NUM_CH  per-channel synchronous counter clear
level_o  out  NUM_CH  synchronized and filtered level
rise_o  out  NUM_CH  1-cycle pulse on level 0->1
fall_o  out  NUM_CH  1-cycle pulse on level 1->0
stretch_o  out  NUM_CH  high while stretch counter is nonzero
evt_cnt_o  out  NUM_CH*CNT_W  event counters, ch0 in LSBs

Behaviour:
Clock and reset:
- One clock, clk27. Reset is asynchronous, active-low on reset_n.

Reset values:
- Sync chain = RESET_VAL; level_o = RESET_VAL; internal level_d = RESET_VAL.
- Debounce, stretch and event counters = 0.
- rise_o = fall_o = stretch_o = 0.
- Exiting reset produces no spurious edge.

Synchronizer:
- s = last flop of an SYNC_STAGES-deep chain.
- s lags in_i by SYNC_STAGES cycles.

Filter (per channel):
- Effective limit L = debounce_en ? max(debounce_limit, 1) : 1.
- If s == level: dcnt <= 0.
- Else if dcnt == L-1: level <= s, dcnt <= 0.
- Else: dcnt <= dcnt+1.
- Result: a change on s that persists for L consecutive cycles updates level_o L cycles after s changes.
- A glitch shorter than L cycles is rejected and dcnt restarts.
- With L = 1 the level follows s with 1-cycle latency, so total in_i -> level_o latency = SYNC_STAGES + 1.
- Changing debounce_limit while dcnt > 0 compares against the new value on the next cycle. If dcnt >= L-1 already, the level updates on the next cycle where s != level.

Edges:
- level_d <= level every cycle.
- rise_o = level & ~level_d; fall_o = ~level & level_d.
- Both are derived purely from registers; each pulse is exactly 1 cycle, 1 cycle after the level_o change.

Event:
- evt = (evt_sel[1] & fall) | (evt_sel[0] & rise).

Stretcher:
- On evt: scnt <= all-ones. This reloads even while already nonzero (retrigger).
- Else if scnt != 0: scnt <= scnt-1.
- stretch_o = (scnt != 0).
- stretch_o rises the cycle after the edge pulse and stays high for 2^STRETCH_W-1 cycles after the last event.

Event counter:
- Wraps modulo 2^CNT_W, no saturation.
- clr && evt -> 1; clr alone -> 0; evt alone -> +1.

Channels:
- Channels are fully independent; simultaneous events on different channels are all counted.

Reset mid-operation:
- All state returns immediately to the reset values above; no pulse is emitted on release.

Decomposition:
Package async_input_pkg contains:
- EVT_NONE/EVT_RISE/EVT_FALL/EVT_BOTH 2-bit constants;
- a function computing the effective limit L.

Sub-module input_cond_ch holds one channel: sync chain, filter, edge, stretcher and counter, parametrised identically. The top generates NUM_CH instances and packs evt_cnt_o.

Test Plan:
All scenarios use NUM_CH=2, SYNC_STAGES=2, STRETCH_W=4, CNT_W=4, RESET_VAL=2'b11.

1. Reset release with in_i=11 -> level_o=11, no rise_o/fall_o pulse for 20 cycles, evt_cnt_o=0.
2. debounce_en=0, in_i[0] 1->0 at cycle 0 -> level_o[0]=0 at cycle 3, fall_o[0] pulse at cycle 4 only.
3. debounce_en=1, limit=4:
   - 3-cycle low glitch on in_i[1] -> level_o[1] stays 1;
   - 4-cycle low pulse -> level_o[1]=0 exactly 4 cycles after s changes.
4. evt_sel[1:0]=11, toggle ch0 once -> stretch_o[0] high for 15 cycles. A second event at cycle 10 of the stretch extends it to 15 cycles after that event.
5. evt_sel=01, 17 rising edges -> evt_cnt_o[3:0] wraps to 1; fall edges do not count.
6. evt_cnt_clr[0] asserted in the same cycle as a counted edge -> count=1. Reset asserted mid-stretch and mid-debounce -> all counters 0, stretch_o=0 immediately.
